// File: rtl/float_decoder_pipe.sv
// float_decoder_pipe: two-stage, valid/ready IEEE-754 binary16/32/64 unpacker.
// Stage 1 splits the word, classifies it and counts leading zeros of the
// fraction. Stage 2 unbiases the exponent and normalises subnormals so the
// consumer always sees a hidden-1 significand.
module float_decoder_pipe #(
    parameter int  FSIZE     = 64,
    localparam int EXP_SIZE  = (FSIZE == 16) ? 5 : (FSIZE == 32) ? 8 : 11,
    localparam int MANT_SIZE = FSIZE - 1 - EXP_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [FSIZE-1:0]      bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sign,
    output logic [EXP_SIZE:0]     exp,
    output logic [MANT_SIZE-1:0]  frac,
    output logic                  is_zero,
    output logic                  is_subnormal,
    output logic                  is_inf,
    output logic                  is_nan
);

    localparam int XW   = EXP_SIZE + 1;
    localparam int LZW  = $clog2(MANT_SIZE + 1);
    localparam int BIAS = (1 << (EXP_SIZE - 1)) - 1;

    if (!(FSIZE == 16 || FSIZE == 32 || FSIZE == 64)) begin : g_bad_fsize
        $error("float_decoder_pipe: FSIZE must be 16, 32 or 64");
    end

    logic                  v1, v2, adv;
    logic                  s1_sign;
    logic [EXP_SIZE-1:0]   s1_e;
    logic [MANT_SIZE-1:0]  s1_f;
    logic [LZW-1:0]        s1_lz;
    logic                  s1_zero, s1_sub, s1_inf, s1_nan;

    logic [EXP_SIZE-1:0]   in_e;
    logic [MANT_SIZE-1:0]  in_f;
    logic [LZW-1:0]        in_lz;
    logic                  e_max, e_zero, f_zero;

    logic [XW-1:0]         exp_d;
    logic [MANT_SIZE-1:0]  frac_d;

    assign in_e   = bits[FSIZE-2 -: EXP_SIZE];
    assign in_f   = bits[MANT_SIZE-1:0];
    assign e_max  = &in_e;
    assign e_zero = ~|in_e;
    assign f_zero = ~|in_f;

    // Stage 2 advances when empty or drained; stage 1 refills behind it.
    assign adv       = !v2 || out_ready;
    assign in_ready  = !v1 || adv;
    assign out_valid = v2;

    // Leading-zero count of the fraction; the highest set bit wins the scan.
    always_comb begin
        in_lz = '0;
        for (int i = 0; i < MANT_SIZE; i++) begin
            if (in_f[i]) in_lz = LZW'(MANT_SIZE - 1 - i);
        end
    end

    // Stage 1: capture fields, class and leading-zero count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1      <= 1'b0;
            s1_sign <= 1'b0;
            s1_e    <= '0;
            s1_f    <= '0;
            s1_lz   <= '0;
            s1_zero <= 1'b0;
            s1_sub  <= 1'b0;
            s1_inf  <= 1'b0;
            s1_nan  <= 1'b0;
        end else begin
            if (in_ready) v1 <= in_valid;
            if (in_valid && in_ready) begin
                s1_sign <= bits[FSIZE-1];
                s1_e    <= in_e;
                s1_f    <= in_f;
                s1_lz   <= in_lz;
                s1_zero <= e_zero && f_zero;
                s1_sub  <= e_zero && !f_zero;
                s1_inf  <= e_max && f_zero;
                s1_nan  <= e_max && !f_zero;
            end
        end
    end

    // Unbias exponent; subnormals shift their leading 1 out into the hidden bit.
    always_comb begin
        exp_d  = '0;
        frac_d = '0;
        if (s1_sub) begin
            exp_d  = XW'(0) - XW'(BIAS) - XW'(s1_lz);
            frac_d = s1_f << (s1_lz + LZW'(1));
        end else if (s1_nan) begin
            frac_d = s1_f;
        end else if (!s1_zero && !s1_inf) begin
            exp_d  = XW'(s1_e) - XW'(BIAS);
            frac_d = s1_f;
        end
    end

    // Stage 2: output register, held while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v2           <= 1'b0;
            sign         <= 1'b0;
            exp          <= '0;
            frac         <= '0;
            is_zero      <= 1'b0;
            is_subnormal <= 1'b0;
            is_inf       <= 1'b0;
            is_nan       <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                sign         <= s1_sign;
                exp          <= exp_d;
                frac         <= frac_d;
                is_zero      <= s1_zero;
                is_subnormal <= s1_sub;
                is_inf       <= s1_inf;
                is_nan       <= s1_nan;
            end
        end
    end

endmodule

// File: tb/tb_float_decoder_pipe.sv
// Directed bench for float_decoder_pipe: FSIZE=64 vector table driven through
// streaming and stalled runs, reset checks, plus small FSIZE=32/16 instances.
module tb_float_decoder_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // FSIZE=64 instance
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic        in_ready, out_valid, sign, is_zero, is_subnormal, is_inf, is_nan;
    logic [63:0] bits = '0;
    logic [11:0] exp;
    logic [51:0] frac;

    float_decoder_pipe #(.FSIZE(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .bits(bits),
        .out_valid(out_valid), .out_ready(out_ready), .sign(sign), .exp(exp), .frac(frac),
        .is_zero(is_zero), .is_subnormal(is_subnormal), .is_inf(is_inf), .is_nan(is_nan)
    );

    // FSIZE=32 instance
    logic        a_valid = 1'b0, a_ready, a_ovalid, a_sign, a_z, a_s, a_i, a_n;
    logic [31:0] a_bits = '0;
    logic [8:0]  a_exp;
    logic [22:0] a_frac;

    float_decoder_pipe #(.FSIZE(32)) dut32 (
        .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .bits(a_bits),
        .out_valid(a_ovalid), .out_ready(1'b1), .sign(a_sign), .exp(a_exp), .frac(a_frac),
        .is_zero(a_z), .is_subnormal(a_s), .is_inf(a_i), .is_nan(a_n)
    );

    // FSIZE=16 instance
    logic        h_valid = 1'b0, h_ready, h_ovalid, h_sign, h_z, h_s, h_i, h_n;
    logic [15:0] h_bits = '0;
    logic [5:0]  h_exp;
    logic [9:0]  h_frac;

    float_decoder_pipe #(.FSIZE(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(h_valid), .in_ready(h_ready), .bits(h_bits),
        .out_valid(h_ovalid), .out_ready(1'b1), .sign(h_sign), .exp(h_exp), .frac(h_frac),
        .is_zero(h_z), .is_subnormal(h_s), .is_inf(h_i), .is_nan(h_n)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // fl = {zero, subnormal, inf, nan}
    typedef struct {
        logic [63:0] bits;
        logic        sgn;
        int          ex;
        logic [51:0] fr;
        logic [3:0]  fl;
    } vec_t;

    vec_t vec[14];

    function automatic logic [127:0] act64();
        return {59'b0, sign, exp, frac, is_zero, is_subnormal, is_inf, is_nan};
    endfunction

    function automatic logic [127:0] want64(input vec_t v);
        return {59'b0, v.sgn, 12'(v.ex), v.fr, v.fl};
    endfunction

    // Drives vec[first..first+n-1] back to back; out_ready is low for
    // loop cycles [stall_start, stall_start+stall_len).
    task automatic run_stream(input int first, input int n, input int stall_start,
                              input int stall_len, output int first_out, output int gaps,
                              output int ready_drops, output int blocked_at);
        int in_idx, out_idx, cyc;
        logic held;
        logic [127:0] snap;
        in_idx = first; out_idx = first; cyc = 0;
        first_out = -1; gaps = 0; ready_drops = 0; blocked_at = -1;
        held = 1'b0; snap = '0;
        while (out_idx < first + n && cyc < 200) begin
            @(negedge clk);
            in_valid  = (in_idx < first + n);
            bits      = in_valid ? vec[in_idx].bits : 64'h0;
            out_ready = !(cyc >= stall_start && cyc < stall_start + stall_len);
            #1;
            if (held)
                check($sformatf("hold_stable_c%0d", cyc), {out_valid, act64()}, {1'b1, snap});
            held = out_valid && !out_ready;
            snap = act64();
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                check($sformatf("vec%0d", out_idx), act64(), want64(vec[out_idx]));
                out_idx++;
            end else if (first_out >= 0 && out_ready) begin
                gaps++;
            end
            if (in_valid && !in_ready) begin
                ready_drops++;
                if (blocked_at < 0) blocked_at = in_idx - first;
            end
            if (in_valid && in_ready) in_idx++;
            cyc++;
        end
        if (out_idx < first + n)
            check("stream_timeout", 128'(out_idx), 128'(first + n));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic run32(input string name, input logic [31:0] b, input logic s, input int e,
                         input logic [22:0] f, input logic [3:0] fl);
        int t;
        @(negedge clk);
        a_valid = 1'b1; a_bits = b;
        @(negedge clk);
        a_valid = 1'b0;
        t = 0;
        while (!a_ovalid && t < 10) begin @(negedge clk); t++; end
        check(name, {a_ovalid, a_sign, a_exp, a_frac, a_z, a_s, a_i, a_n},
                    {1'b1, s, 9'(e), f, fl});
    endtask

    task automatic run16(input string name, input logic [15:0] b, input logic s, input int e,
                         input logic [9:0] f, input logic [3:0] fl);
        int t;
        @(negedge clk);
        h_valid = 1'b1; h_bits = b;
        @(negedge clk);
        h_valid = 1'b0;
        t = 0;
        while (!h_ovalid && t < 10) begin @(negedge clk); t++; end
        check(name, {h_ovalid, h_sign, h_exp, h_frac, h_z, h_s, h_i, h_n},
                    {1'b1, s, 6'(e), f, fl});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int fo, gp, rd, ba;

        vec[0]  = '{64'h405EE00000000000, 1'b0,     6, 52'hEE00000000000, 4'b0000};
        vec[1]  = '{64'h0000000000000001, 1'b0, -1074, 52'h0,             4'b0100};
        vec[2]  = '{64'h0008000000000000, 1'b0, -1023, 52'h0,             4'b0100};
        vec[3]  = '{64'h8000000000000000, 1'b1,     0, 52'h0,             4'b1000};
        vec[4]  = '{64'h7FF0000000000000, 1'b0,     0, 52'h0,             4'b0010};
        vec[5]  = '{64'hFFF8000000000001, 1'b1,     0, 52'h8000000000001, 4'b0001};
        vec[6]  = '{64'h3FF0000000000000, 1'b0,     0, 52'h0,             4'b0000};
        vec[7]  = '{64'hC000000000000000, 1'b1,     1, 52'h0,             4'b0000};
        vec[8]  = '{64'h0000000000000000, 1'b0,     0, 52'h0,             4'b1000};
        vec[9]  = '{64'hFFF0000000000000, 1'b1,     0, 52'h0,             4'b0010};
        vec[10] = '{64'h000C000000000000, 1'b0, -1023, 52'h8000000000000, 4'b0100};
        vec[11] = '{64'h7FEFFFFFFFFFFFFF, 1'b0,  1023, 52'hFFFFFFFFFFFFF, 4'b0000};
        vec[12] = '{64'h0010000000000000, 1'b0, -1022, 52'h0,             4'b0000};
        vec[13] = '{64'h800FFFFFFFFFFFFF, 1'b1, -1023, 52'hFFFFFFFFFFFFE, 4'b0100};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs", {out_valid, act64()}, 128'h0);
        rst = 1'b1;
        #1;
        check("ready_after_reset", 128'(in_ready), 128'h1);
        check("valid_after_reset", 128'(out_valid), 128'h0);

        // Back-to-back stream: 2-edge latency, no bubbles, in_ready never drops
        run_stream(0, 14, 1000, 0, fo, gp, rd, ba);
        check("stream_latency", 128'(fo), 128'd2);
        check("stream_gaps", 128'(gp), 128'd0);
        check("stream_ready_drops", 128'(rd), 128'd0);

        // Backpressure: consumer stalls 5 cycles while 3 words are offered
        run_stream(4, 3, 0, 5, fo, gp, rd, ba);
        check("stall_accepts_before_block", 128'(ba), 128'd2);
        check("stall_ready_drops", 128'(rd > 0), 128'd1);

        // Reset with both stages full discards everything at once
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; bits = vec[0].bits;
        @(negedge clk);
        bits = vec[11].bits;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("full_before_reset", {126'b0, out_valid, in_ready}, 128'b10);
        #2;
        rst = 1'b0;
        #1;
        check("reset_midflight_outputs", {out_valid, act64()}, 128'h0);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        #1;
        check("ready_after_midreset", 128'(in_ready), 128'h1);
        repeat (3) @(negedge clk);
        check("no_stale_after_midreset", 128'(out_valid), 128'h0);

        // Narrower formats
        run32("f32_one",     32'h3F800000, 1'b0,    0, 23'h0,      4'b0000);
        run32("f32_min_sub", 32'h00000001, 1'b0, -149, 23'h0,      4'b0100);
        run32("f32_neg_pi",  32'hC0490FDB, 1'b1,    1, 23'h490FDB, 4'b0000);
        run32("f32_qnan",    32'h7FC00000, 1'b0,    0, 23'h400000, 4'b0001);
        run16("f16_min_sub", 16'h0001, 1'b0, -24, 10'h0,   4'b0100);
        run16("f16_one",     16'h3C00, 1'b0,   0, 10'h0,   4'b0000);
        run16("f16_neg_inf", 16'hFC00, 1'b1,   0, 10'h0,   4'b0010);
        run16("f16_sub_300", 16'h0300, 1'b0, -15, 10'h200, 4'b0100);
        run16("f16_snan",    16'h7C01, 1'b0,   0, 10'h1,   4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
